// File: rtl/rt_scene_pkg.sv
// Constants shared between the host-side streamer and the ray-tracing coprocessor:
// payload geometry, field offsets inside the scene payload and the streamer FSM encoding.
package rt_scene_pkg;

    localparam int WORD_LEN         = 32;
    localparam int PAYLOAD_WORDS    = 27;
    localparam int ADDR_W           = 5;
    localparam int COORD_W          = 16;

    localparam int OFF_IMAGE_WIDTH  = 1;
    localparam int OFF_IMAGE_HEIGHT = 2;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SEND_SCENE = 2'd1,
        ST_RECV_FRAG  = 2'd2
    } state_t;

endpackage

// File: rtl/scene_cfg_regs.sv
// Scene payload register file: one synchronous write port, one async read port for the
// word being streamed, and dedicated async taps for image width and height.
// Contents are deliberately not reset so a payload survives a mid-frame reset.
module scene_cfg_regs
    import rt_scene_pkg::*;
(
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [WORD_LEN-1:0] wdata,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [WORD_LEN-1:0] rdata,
    output logic [WORD_LEN-1:0] width,
    output logic [WORD_LEN-1:0] height
);

    logic [WORD_LEN-1:0] mem [PAYLOAD_WORDS];

    // Write port; addresses past the payload are dropped.
    always_ff @(posedge clk) begin
        if (we && (waddr < ADDR_W'(PAYLOAD_WORDS))) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata  = (raddr < ADDR_W'(PAYLOAD_WORDS)) ? mem[raddr] : '0;
    assign width  = mem[OFF_IMAGE_WIDTH];
    assign height = mem[OFF_IMAGE_HEIGHT];

endmodule

// File: rtl/scene_streamer.sv
// Host-side peer of the ray-tracing coprocessor. Streams the scene payload out on an AXIS
// master, then sinks the fragment stream and turns each fragment into an (x,y) pixel write.
// AXIS handshake: a beat transfers on a rising edge where tvalid and tready are both high;
// once tvalid is raised, tvalid/tdata/tlast stay stable until that transfer happens.
module scene_streamer
    import rt_scene_pkg::*;
(
    input  logic                aclk,
    input  logic                resetn,
    input  logic                cfg_we,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [WORD_LEN-1:0] cfg_wdata,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                err_len,
    output logic                m_axis_tvalid,
    output logic [WORD_LEN-1:0] m_axis_tdata,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready,
    input  logic                s_axis_tvalid,
    input  logic [WORD_LEN-1:0] s_axis_tdata,
    input  logic                s_axis_tlast,
    output logic                s_axis_tready,
    output logic                pix_valid,
    output logic [COORD_W-1:0]  pix_x,
    output logic [COORD_W-1:0]  pix_y,
    output logic [WORD_LEN-1:0] pix_data
);

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [WORD_LEN-1:0] count;
    logic [WORD_LEN-1:0] expected;
    logic [WORD_LEN-1:0] width_q;
    logic                abort_pend;

    logic [ADDR_W-1:0]   rd_addr;
    logic [WORD_LEN-1:0] rd_data;
    logic [WORD_LEN-1:0] cfg_width;
    logic [WORD_LEN-1:0] cfg_height;
    logic                m_hs;
    logic                s_hs;
    logic                last_word;
    logic                x_last;

    // The read port looks one word ahead so tdata can be registered on the handshake.
    assign rd_addr   = (state == ST_IDLE) ? '0 : idx + ADDR_W'(1);
    assign m_hs      = m_axis_tvalid && m_axis_tready;
    assign s_hs      = s_axis_tvalid && s_axis_tready;
    assign last_word = (idx == ADDR_W'(PAYLOAD_WORDS - 1));
    // width==0 gives an all-ones compare value that a COORD_W-bit x never reaches.
    assign x_last    = ({{(WORD_LEN-COORD_W){1'b0}}, x} == (width_q - WORD_LEN'(1)));

    scene_cfg_regs u_regs (
        .clk    (aclk),
        .we     (cfg_we && (state == ST_IDLE)),
        .waddr  (cfg_addr),
        .wdata  (cfg_wdata),
        .raddr  (rd_addr),
        .rdata  (rd_data),
        .width  (cfg_width),
        .height (cfg_height)
    );

    // Frame sequencer: scene out, fragments in, with all outputs registered.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            idx           <= '0;
            x             <= '0;
            y             <= '0;
            count         <= '0;
            expected      <= '0;
            width_q       <= '0;
            abort_pend    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_len       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            s_axis_tready <= 1'b0;
            pix_valid     <= 1'b0;
            pix_x         <= '0;
            pix_y         <= '0;
            pix_data      <= '0;
        end else begin
            done      <= 1'b0;
            pix_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        expected      <= cfg_width * cfg_height;
                        width_q       <= cfg_width;
                        err_len       <= 1'b0;
                        idx           <= '0;
                        x             <= '0;
                        y             <= '0;
                        count         <= '0;
                        abort_pend    <= 1'b0;
                        busy          <= 1'b1;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= rd_data;
                        m_axis_tlast  <= (PAYLOAD_WORDS == 1);
                        state         <= ST_SEND_SCENE;
                    end
                end
                ST_SEND_SCENE: begin
                    // Abort is remembered and honoured only once the whole scene is out.
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (m_hs) begin
                        if (last_word) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            if (abort_pend || abort) begin
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                s_axis_tready <= 1'b1;
                                state         <= ST_RECV_FRAG;
                            end
                        end else begin
                            idx          <= idx + ADDR_W'(1);
                            m_axis_tdata <= rd_data;
                            m_axis_tlast <= (rd_addr == ADDR_W'(PAYLOAD_WORDS - 1));
                        end
                    end
                end
                ST_RECV_FRAG: begin
                    if (s_hs) begin
                        pix_valid <= 1'b1;
                        pix_data  <= s_axis_tdata;
                        pix_x     <= x;
                        pix_y     <= y;
                        count     <= count + WORD_LEN'(1);
                        if (x_last) begin
                            x <= '0;
                            y <= y + COORD_W'(1);
                        end else begin
                            x <= x + COORD_W'(1);
                        end
                    end
                    if (s_hs && s_axis_tlast) begin
                        done          <= 1'b1;
                        busy          <= 1'b0;
                        s_axis_tready <= 1'b0;
                        err_len       <= ((count + WORD_LEN'(1)) != expected);
                        state         <= ST_IDLE;
                    end else if (abort) begin
                        busy          <= 1'b0;
                        s_axis_tready <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scene_streamer.sv
// Bench for scene_streamer: randomized frames driven by tasks, expected scene beats and pixel
// writes pushed into queues by the drivers and popped by independent monitors.
module tb_scene_streamer;
    import rt_scene_pkg::*;

    localparam int NW = PAYLOAD_WORDS;

    logic                aclk = 1'b0;
    logic                resetn = 1'b0;
    logic                cfg_we = 1'b0;
    logic [ADDR_W-1:0]   cfg_addr = '0;
    logic [WORD_LEN-1:0] cfg_wdata = '0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic                busy, done, err_len;
    logic                m_axis_tvalid, m_axis_tlast;
    logic [WORD_LEN-1:0] m_axis_tdata;
    logic                m_axis_tready = 1'b0;
    logic                s_axis_tvalid = 1'b0;
    logic [WORD_LEN-1:0] s_axis_tdata = '0;
    logic                s_axis_tlast = 1'b0;
    logic                s_axis_tready;
    logic                pix_valid;
    logic [COORD_W-1:0]  pix_x, pix_y;
    logic [WORD_LEN-1:0] pix_data;

    scene_streamer dut (
        .aclk          (aclk),
        .resetn        (resetn),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .start         (start),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .err_len       (err_len),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .pix_valid     (pix_valid),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_data      (pix_data)
    );

    // clock / reset
    always #5 aclk = ~aclk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int scene_beats = 0;
    int first_beat_cyc = 0;
    int last_beat_cyc = 0;
    int done_cnt = 0;

    logic [WORD_LEN:0]   exp_scene_q[$];   // {tlast, data}
    logic [63:0]         exp_pix_q[$];     // {x, y, data}
    logic [WORD_LEN-1:0] cfg_model [NW];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge aclk) cyc++;

    // scene monitor: order, content, tlast placement and stability under back-pressure
    logic                prev_stall = 1'b0;
    logic [WORD_LEN-1:0] prev_tdata = '0;
    logic                prev_tlast = 1'b0;
    logic [WORD_LEN:0]   scene_exp;
    always @(negedge aclk) begin
        if (resetn) begin
            if (prev_stall) begin
                check("scene_hold", {31'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                      {31'd0, 1'b1, prev_tlast, prev_tdata});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_scene_q.size() == 0) begin
                    check("scene_unexpected", 64'd1, 64'd0);
                end else begin
                    scene_exp = exp_scene_q.pop_front();
                    check("scene_word", {31'd0, m_axis_tlast, m_axis_tdata}, {31'd0, scene_exp});
                end
                if (scene_beats == 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                scene_beats++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_tdata = m_axis_tdata;
            prev_tlast = m_axis_tlast;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // pixel monitor and done counter
    logic [63:0] pix_exp;
    always @(negedge aclk) begin
        if (resetn && pix_valid) begin
            if (exp_pix_q.size() == 0) begin
                check("pix_unexpected", 64'd1, 64'd0);
            end else begin
                pix_exp = exp_pix_q.pop_front();
                check("pix_write", {pix_x, pix_y, pix_data}, pix_exp);
            end
        end
        if (resetn && done) done_cnt++;
    end

    task automatic cfg_write(input int addr, input logic [WORD_LEN-1:0] data);
        @(posedge aclk); #1;
        cfg_we = 1'b1;
        cfg_addr = ADDR_W'(addr);
        cfg_wdata = data;
        @(posedge aclk); #1;
        cfg_we = 1'b0;
        if (addr < NW) cfg_model[addr] = data;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {busy, done, err_len, m_axis_tvalid, m_axis_tlast, s_axis_tready, pix_valid},
              64'd0);
        check({name, "_data"}, {pix_x, pix_y, m_axis_tdata}, 64'd0);
        check({name, "_pixdata"}, {32'd0, pix_data}, 64'd0);
    endtask

    // One frame: abort_scene aborts during the scene; abort_after/reset_after >= 0 abort or
    // reset once that many fragments have been sent; poke issues start and cfg_we while busy.
    task automatic do_frame(input int nfrag, input bit rand_ready, input bit abort_scene,
                            input int abort_after, input int reset_after, input bit poke);
        logic [WORD_LEN-1:0] wd, ht, prod, data;
        int done0, guard, g, k;
        bit cut;
        wd = cfg_model[OFF_IMAGE_WIDTH];
        ht = cfg_model[OFF_IMAGE_HEIGHT];
        prod = wd * ht;
        for (int i = 0; i < NW; i++) exp_scene_q.push_back({(i == NW - 1), cfg_model[i]});
        scene_beats = 0;
        done0 = done_cnt;

        @(posedge aclk); #1;
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        guard = 0;
        while (scene_beats < NW && guard < 1000) begin
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start  = (poke && guard == 3);
            cfg_we = (poke && guard == 3);
            cfg_addr = ADDR_W'(5);
            cfg_wdata = 32'hdead_beef;
            abort  = (abort_scene && guard == 5);
            @(posedge aclk); #1;
            guard++;
        end
        start = 1'b0;
        cfg_we = 1'b0;
        abort = 1'b0;
        m_axis_tready = 1'b0;
        check("scene_beat_count", 64'(scene_beats), 64'(NW));
        check("scene_queue_empty", 64'(exp_scene_q.size()), 64'd0);
        if (!rand_ready) check("scene_cycles", 64'(last_beat_cyc - first_beat_cyc), 64'(NW - 1));

        if (abort_scene) begin
            @(negedge aclk);
            check("abort_scene_busy", {63'd0, busy}, 64'd0);
            check("abort_scene_sready", {63'd0, s_axis_tready}, 64'd0);
            repeat (3) @(negedge aclk);
            check("abort_scene_no_done", 64'(done_cnt - done0), 64'd0);
            return;
        end

        cut = 1'b0;
        for (k = 0; k < nfrag; k++) begin
            if (k == abort_after) begin
                cut = 1'b1;
                break;
            end
            if (k == reset_after) begin
                s_axis_tvalid = 1'b0;
                @(negedge aclk); #2;
                resetn = 1'b0;
                #1;
                check_all_zero("reset_mid_frame");
                exp_pix_q.delete();
                @(posedge aclk); #1;
                resetn = 1'b1;
                return;
            end
            if ($urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                @(posedge aclk); #1;
            end
            data = $urandom;
            s_axis_tvalid = 1'b1;
            s_axis_tdata = data;
            s_axis_tlast = (k == nfrag - 1);
            start  = (poke && k == 1);
            cfg_we = (poke && k == 1);
            if (wd == 0) exp_pix_q.push_back({16'(k), 16'd0, data});
            else exp_pix_q.push_back({16'(k % int'(wd)), 16'(k / int'(wd)), data});
            g = 0;
            @(negedge aclk);
            while (!s_axis_tready && g < 50) begin
                @(negedge aclk);
                g++;
            end
            if (g >= 50) check("frag_timeout", 64'd0, 64'd1);
            @(posedge aclk); #1;
            start = 1'b0;
            cfg_we = 1'b0;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;

        if (cut) begin
            abort = 1'b1;
            @(posedge aclk); #1;
            abort = 1'b0;
            @(negedge aclk);
            check("abort_recv_sready", {63'd0, s_axis_tready}, 64'd0);
            check("abort_recv_busy", {63'd0, busy}, 64'd0);
            repeat (3) @(negedge aclk);
            check("abort_recv_no_done", 64'(done_cnt - done0), 64'd0);
            check("abort_recv_pix_left", 64'(exp_pix_q.size()), 64'd0);
        end else begin
            @(negedge aclk);
            check("end_done", {63'd0, done}, 64'd1);
            check("end_busy", {63'd0, busy}, 64'd0);
            check("end_sready", {63'd0, s_axis_tready}, 64'd0);
            check("end_err_len", {63'd0, err_len}, {63'd0, (WORD_LEN'(nfrag) != prod)});
            @(negedge aclk);
            check("done_one_cycle", {63'd0, done}, 64'd0);
            check("err_len_sticky", {63'd0, err_len}, {63'd0, (WORD_LEN'(nfrag) != prod)});
            check("done_count", 64'(done_cnt - done0), 64'd1);
            check("pix_left", 64'(exp_pix_q.size()), 64'd0);
        end
    endtask

    initial begin
        int w, h, n;
        repeat (3) @(posedge aclk);
        #1;
        check_all_zero("reset_state");
        resetn = 1'b1;

        // payload 0x100+i, 4x2 image, full-rate scene and exact fragment count
        for (int i = 0; i < NW; i++) cfg_write(i, 32'h100 + i);
        cfg_write(OFF_IMAGE_WIDTH, 4);
        cfg_write(OFF_IMAGE_HEIGHT, 2);
        for (int a = NW; a < 32; a++) cfg_write(a, $urandom);
        do_frame(8, 1'b0, 1'b0, -1, -1, 1'b0);

        // back-pressure on the scene stream
        do_frame(8, 1'b1, 1'b0, -1, -1, 1'b0);

        // short and long frames
        do_frame(6, 1'b0, 1'b0, -1, -1, 1'b0);
        do_frame(10, 1'b1, 1'b0, -1, -1, 1'b0);

        // start and config writes while busy are ignored; re-run sees the same payload
        do_frame(8, 1'b0, 1'b0, -1, -1, 1'b1);
        do_frame(8, 1'b0, 1'b0, -1, -1, 1'b0);

        // abort during the scene, then abort after three fragments
        do_frame(8, 1'b1, 1'b1, -1, -1, 1'b0);
        do_frame(8, 1'b0, 1'b0, 3, -1, 1'b0);

        // reset in the middle of fragment reception, then the retained payload is re-sent
        do_frame(8, 1'b0, 1'b0, -1, 3, 1'b0);
        do_frame(8, 1'b0, 1'b0, -1, -1, 1'b0);

        // zero width: x never wraps, length always reported wrong
        cfg_write(OFF_IMAGE_WIDTH, 0);
        cfg_write(OFF_IMAGE_HEIGHT, 3);
        do_frame(5, 1'b0, 1'b0, -1, -1, 1'b0);

        // random geometry, payload and fragment counts
        repeat (4) begin
            w = $urandom_range(1, 5);
            h = $urandom_range(1, 3);
            n = w * h + $urandom_range(0, 3) - 1;
            if (n < 1) n = 1;
            cfg_write($urandom_range(3, NW - 1), $urandom);
            cfg_write(0, $urandom);
            cfg_write(OFF_IMAGE_WIDTH, w);
            cfg_write(OFF_IMAGE_HEIGHT, h);
            do_frame(n, 1'b1, 1'b0, -1, -1, 1'b0);
        end

        repeat (3) @(posedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
